// File: rtl/pb_kbd_event_queue.sv
// Push-button release event queue feeding the KBSR/KBDR keyboard registers.
// A round-robin arbiter moves pending key events into a small FIFO that the processor drains via KBDR reads.
module pb_kbd_event_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             proc_clk,
    input  logic             reset,
    input  logic [4:0]       key_evt,
    input  logic             read_kbsr,
    input  logic             read_kbdr,
    output logic             kbsr,
    output logic [7:0]       kbdr,
    output logic [PTR_W:0]   count,
    output logic             overflow
);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_ZERO = (PTR_W+1)'(0);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    // Key index to ASCII code.
    function automatic logic [7:0] key_code(input logic [2:0] idx);
        logic [7:0] code;
        case (idx)
            3'd4:    code = 8'h69;
            3'd3:    code = 8'h6A;
            3'd2:    code = 8'h6B;
            3'd1:    code = 8'h6C;
            3'd0:    code = 8'h20;
            default: code = 8'h00;
        endcase
        return code;
    endfunction

    // Next index in descending round-robin order over 4..0.
    function automatic logic [2:0] prev_idx(input logic [2:0] idx);
        logic [2:0] nxt;
        if (idx == 3'd0) begin
            nxt = 3'd4;
        end else begin
            nxt = idx - 3'd1;
        end
        return nxt;
    endfunction

    logic [4:0]       pend_q, pend_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [2:0]       last_grant_q, last_grant_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       mem_q [DEPTH];
    logic [7:0]       mem_d [DEPTH];

    logic             pop_s;
    logic             push_s;
    logic             fifo_free_s;
    logic             grant_vld_s;
    logic [2:0]       grant_idx_s;
    logic [2:0]       cand_s;
    logic [4:0]       grant_s;
    logic             merge_s;

    // Pop qualification and FIFO space (a same-cycle pop frees a slot).
    always_comb begin
        pop_s       = read_kbdr && (count_q != CNT_ZERO);
        fifo_free_s = (count_q < FULL_CNT) || pop_s;
    end

    // Round-robin arbiter: search starts just below the last granted index.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = last_grant_q;
        cand_s      = prev_idx(last_grant_q);
        if (fifo_free_s) begin
            for (int i = 0; i < 5; i++) begin
                if (!grant_vld_s && pend_q[cand_s]) begin
                    grant_vld_s = 1'b1;
                    grant_idx_s = cand_s;
                end else begin
                    grant_vld_s = grant_vld_s;
                end
                cand_s = prev_idx(cand_s);
            end
        end else begin
            grant_vld_s = 1'b0;
        end
        if (grant_vld_s) begin
            grant_s = 5'b00001 << grant_idx_s;
        end else begin
            grant_s = 5'b00000;
        end
        push_s = grant_vld_s;
    end

    // Pending events, merge detection and the sticky overflow flag.
    always_comb begin
        pend_d  = (pend_q & ~grant_s) | key_evt;
        merge_s = |(key_evt & pend_q & ~grant_s);
        if (merge_s) begin
            overflow_d = 1'b1;
        end else if (read_kbsr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
        if (grant_vld_s) begin
            last_grant_d = grant_idx_s;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // FIFO storage, pointers and occupancy.
    always_comb begin
        mem_d = mem_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = key_code(grant_idx_s);
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge proc_clk) begin
        if (!reset) begin
            pend_q       <= 5'b00000;
            wr_ptr_q     <= {PTR_W{1'b0}};
            rd_ptr_q     <= {PTR_W{1'b0}};
            count_q      <= CNT_ZERO;
            last_grant_q <= 3'd0;
            overflow_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            pend_q       <= pend_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            last_grant_q <= last_grant_d;
            overflow_q   <= overflow_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Outputs decode registered state only; no input-to-output path.
    always_comb begin
        kbsr     = (count_q != CNT_ZERO);
        count    = count_q;
        overflow = overflow_q;
        if (count_q != CNT_ZERO) begin
            kbdr = mem_q[rd_ptr_q];
        end else begin
            kbdr = 8'h00;
        end
    end

endmodule

// File: tb/tb_pb_kbd_event_queue.sv
// Self-checking bench for pb_kbd_event_queue: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_pb_kbd_event_queue;

    logic       proc_clk;
    logic       reset;
    logic [4:0] key_evt;
    logic       read_kbsr;
    logic       read_kbdr;
    logic       kbsr;
    logic [7:0] kbdr;
    logic [2:0] count;
    logic       overflow;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Reference model state
    logic [7:0] mq[$];
    logic [4:0] m_pend;
    int         m_lg;
    bit         m_ov;
    logic [7:0] codes [5] = '{8'h20, 8'h6C, 8'h6B, 8'h6A, 8'h69};

    pb_kbd_event_queue #(.DEPTH(4), .PTR_W(2)) dut (
        .proc_clk (proc_clk),
        .reset    (reset),
        .key_evt  (key_evt),
        .read_kbsr(read_kbsr),
        .read_kbdr(read_kbdr),
        .kbsr     (kbsr),
        .kbdr     (kbdr),
        .count    (count),
        .overflow (overflow)
    );

    initial proc_clk = 1'b0;
    always #5 proc_clk = ~proc_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge of the specified behaviour, using the inputs present at that edge.
    task automatic model_step();
        int  gi;
        int  c;
        bit  pop;
        bit  free;
        bit  mrg;
        if (!reset) begin
            mq.delete();
            m_pend = 5'b00000;
            m_lg   = 0;
            m_ov   = 1'b0;
        end else begin
            pop  = read_kbdr && (mq.size() > 0);
            free = (mq.size() < 4) || pop;
            gi   = -1;
            if (free) begin
                for (int k = 1; k <= 5; k++) begin
                    c = (m_lg + 5 - k) % 5;
                    if (gi < 0 && m_pend[c]) gi = c;
                end
            end
            mrg = 1'b0;
            for (int b = 0; b < 5; b++) begin
                if (key_evt[b] && m_pend[b] && b != gi) mrg = 1'b1;
            end
            if (pop) void'(mq.pop_front());
            if (gi >= 0) begin
                mq.push_back(codes[gi]);
                m_pend[gi] = 1'b0;
                m_lg = gi;
            end
            if (mrg) m_ov = 1'b1;
            else if (read_kbsr) m_ov = 1'b0;
            m_pend = m_pend | key_evt;
        end
    endtask

    // Per-cycle comparison of DUT outputs with the model.
    always @(negedge proc_clk) begin
        if (chk_en) begin
            check("cyc_kbsr", {31'd0, kbsr}, {31'd0, mq.size() != 0});
            check("cyc_kbdr", {24'd0, kbdr}, (mq.size() != 0) ? {24'd0, mq[0]} : 32'd0);
            check("cyc_count", {29'd0, count}, mq.size());
            check("cyc_overflow", {31'd0, overflow}, {31'd0, m_ov});
        end
    end

    task automatic step(input logic rst_v, input logic [4:0] evt, input logic rk, input logic rd);
        @(negedge proc_clk);
        reset     = rst_v;
        key_evt   = evt;
        read_kbsr = rk;
        read_kbdr = rd;
        @(posedge proc_clk);
        model_step();
        chk_en = 1'b1;
        #1;
        reset     = 1'b1;
        key_evt   = 5'b00000;
        read_kbsr = 1'b0;
        read_kbdr = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 5'b00000, 1'b0, 1'b0);
    endtask

    task automatic pull();
        step(1'b1, 5'b00000, 1'b0, 1'b1);
    endtask

    initial begin
        reset = 1'b0; key_evt = 5'b00000; read_kbsr = 1'b0; read_kbdr = 1'b0;
        m_pend = 5'b00000; m_lg = 0; m_ov = 1'b0;

        // Reset held two edges with events present
        step(1'b0, 5'b10110, 1'b0, 1'b0);
        step(1'b0, 5'b01011, 1'b1, 1'b1);
        check("rst_kbsr", {31'd0, kbsr}, 32'd0);
        check("rst_kbdr", {24'd0, kbdr}, 32'h00);
        check("rst_count", {29'd0, count}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        idle(2);
        check("rst_nopush", {29'd0, count}, 32'd0);

        // Single event latency and pop
        step(1'b1, 5'b10000, 1'b0, 1'b0);
        check("single_lat", {31'd0, kbsr}, 32'd0);
        idle(1);
        check("single_kbsr", {31'd0, kbsr}, 32'd1);
        check("single_kbdr", {24'd0, kbdr}, 32'h69);
        pull();
        check("single_pop_kbsr", {31'd0, kbsr}, 32'd0);
        check("single_pop_kbdr", {24'd0, kbdr}, 32'h00);

        // Burst of all five from reset order
        step(1'b0, 5'b00000, 1'b0, 1'b0);
        step(1'b1, 5'b11111, 1'b0, 1'b0);
        idle(4);
        check("burst_count", {29'd0, count}, 32'd4);
        check("burst_head", {24'd0, kbdr}, 32'h69);
        check("burst_pend", {27'd0, m_pend}, 32'b00001);
        pull(); check("burst_r1", {24'd0, kbdr}, 32'h6A);
        check("burst_r1_cnt", {29'd0, count}, 32'd4);
        pull(); check("burst_r2", {24'd0, kbdr}, 32'h6B);
        pull(); check("burst_r3", {24'd0, kbdr}, 32'h6C);
        pull(); check("burst_r4", {24'd0, kbdr}, 32'h20);
        pull(); check("burst_r5", {24'd0, kbdr}, 32'h00);
        check("burst_ovf", {31'd0, overflow}, 32'd0);

        // Round robin: after granting bit 3, bit 2 beats bit 4
        step(1'b1, 5'b01000, 1'b0, 1'b0);
        idle(1);
        step(1'b1, 5'b10100, 1'b0, 1'b0);
        idle(2);
        check("rr_count", {29'd0, count}, 32'd3);
        check("rr_head", {24'd0, kbdr}, 32'h6A);
        pull(); check("rr_second", {24'd0, kbdr}, 32'h6B);
        pull(); check("rr_third", {24'd0, kbdr}, 32'h69);
        pull(); check("rr_empty", {24'd0, kbdr}, 32'h00);

        // Overflow: fill, then repeat bit 1 while full
        step(1'b1, 5'b11111, 1'b0, 1'b0);
        idle(4);
        check("ovf_full", {29'd0, count}, 32'd4);
        step(1'b1, 5'b00010, 1'b0, 1'b0);
        check("ovf_first", {31'd0, overflow}, 32'd0);
        step(1'b1, 5'b00010, 1'b0, 1'b0);
        check("ovf_set", {31'd0, overflow}, 32'd1);
        check("ovf_pend1", {31'd0, m_pend[1]}, 32'd1);
        step(1'b1, 5'b00000, 1'b1, 1'b0);
        check("ovf_clear", {31'd0, overflow}, 32'd0);
        check("ovf_kbsr_kept", {31'd0, kbsr}, 32'd1);
        step(1'b1, 5'b00010, 1'b1, 1'b0);
        check("ovf_set_wins", {31'd0, overflow}, 32'd1);
        pull();
        check("ovf_pop_push", {29'd0, count}, 32'd4);
        check("ovf_head", {24'd0, kbdr}, 32'h6B);

        // Mid-operation reset, then arbitration restarts at bit 4
        step(1'b0, 5'b00100, 1'b0, 1'b0);
        check("mrst_count", {29'd0, count}, 32'd0);
        check("mrst_kbsr", {31'd0, kbsr}, 32'd0);
        check("mrst_ovf", {31'd0, overflow}, 32'd0);
        step(1'b1, 5'b10001, 1'b0, 1'b0);
        idle(1);
        check("mrst_first", {24'd0, kbdr}, 32'h69);
        idle(1);
        check("mrst_count2", {29'd0, count}, 32'd2);
        pull(); check("mrst_next", {24'd0, kbdr}, 32'h20);
        pull(); check("mrst_empty", {24'd0, kbdr}, 32'h00);
        pull(); check("empty_read", {29'd0, count}, 32'd0);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
